i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target.sv | 227 ++++++++++++++++++++++
 tb/tb_i2c_target.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target exposing a byte-addressed register space through wr_*/rd_* strobes.
// Latency: wr_valid ~3 clk after the SCL fall closing a data byte; rd_data sampled 2 clk after rd_req.
// Backpressure: none; the register side must accept every strobe and return rd_data on time.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h1A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    output logic [7:0] rd_addr,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } state_t;

    state_t      state, state_n;
    logic [1:0]  scl_sync, sda_sync, settle;
    logic        scl_d, sda_d, scl_s, sda_s, armed;
    logic        scl_rise, scl_fall, start_c, stop_c, shift_bit, byte_done;
    logic [3:0]  cnt, cnt_n;
    logic [7:0]  shreg, shreg_n, shreg_sh, tx, tx_n, ptr, ptr_n;
    logic        rw, rw_n, nack, nack_n, sda_oe, sda_oe_n, rd_req_d;
    logic        wr_valid_n, rd_req_n, drive_ok;
    logic [7:0]  wr_addr_n, wr_data_n, rd_addr_n;

    // Edges are suppressed until the synchronizers have flushed their reset value,
    // otherwise SDA held low by the controller would look like a START.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            settle   <= 2'd0;
        end else begin
            scl_sync <= {scl_sync[0], i2c_scl};
            sda_sync <= {sda_sync[0], i2c_sda};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
            if (settle != 2'd3) settle <= settle + 2'd1;
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign armed     = (settle == 2'd3);
    assign scl_rise  = armed & scl_s & ~scl_d;
    assign scl_fall  = armed & ~scl_s & scl_d;
    assign start_c   = armed & scl_s & scl_d & sda_d & ~sda_s;
    assign stop_c    = armed & scl_s & scl_d & ~sda_d & sda_s;
    assign shift_bit = scl_rise & (cnt != 4'd8);
    assign byte_done = scl_fall & (cnt == 4'd8);
    assign shreg_sh  = {shreg[6:0], sda_s};

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        shreg_n    = shreg;
        tx_n       = tx;
        ptr_n      = ptr;
        rw_n       = rw;
        nack_n     = nack;
        sda_oe_n   = sda_oe;
        wr_valid_n = 1'b0;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        rd_req_n   = 1'b0;
        rd_addr_n  = rd_addr;
        if (start_c) begin
            state_n  = ADDR;
            cnt_n    = 4'd0;
            sda_oe_n = 1'b0;
        end else if (stop_c) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (shift_bit) begin
                        shreg_n = shreg_sh;
                        cnt_n   = cnt + 4'd1;
                    end else if (byte_done) begin
                        cnt_n = 4'd0;
                        if (shreg[7:1] == TARGET_ADDR) begin
                            state_n  = ADDR_ACK;
                            rw_n     = shreg[0];
                            sda_oe_n = 1'b1;
                        end else begin
                            state_n  = IGNORE;
                            sda_oe_n = 1'b0;
                        end
                    end
                end
                REG: begin
                    if (shift_bit) begin
                        shreg_n = shreg_sh;
                        cnt_n   = cnt + 4'd1;
                    end else if (byte_done) begin
                        cnt_n    = 4'd0;
                        ptr_n    = shreg;
                        state_n  = REG_ACK;
                        sda_oe_n = 1'b1;
                    end
                end
                WDATA: begin
                    if (shift_bit) begin
                        shreg_n = shreg_sh;
                        cnt_n   = cnt + 4'd1;
                    end else if (byte_done) begin
                        cnt_n      = 4'd0;
                        wr_valid_n = 1'b1;
                        wr_addr_n  = ptr;
                        wr_data_n  = shreg;
                        ptr_n      = ptr + 8'd1;
                        state_n    = WDATA_ACK;
                        sda_oe_n   = 1'b1;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n = 1'b0;
                        cnt_n    = 4'd0;
                        if (rw) begin
                            state_n   = RDATA;
                            rd_req_n  = 1'b1;
                            rd_addr_n = ptr;
                        end else begin
                            state_n = REG;
                        end
                    end
                end
                REG_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n = 1'b0;
                        cnt_n    = 4'd0;
                        state_n  = WDATA;
                    end
                end
                RDATA: begin
                    // SCL low lasts >= 8 clk, so the fetched byte lands before the first fall.
                    if (rd_req_d) begin
                        tx_n     = rd_data;
                        sda_oe_n = ~rd_data[7];
                    end else if (scl_fall) begin
                        if (cnt == 4'd7) begin
                            cnt_n    = 4'd0;
                            sda_oe_n = 1'b0;
                            ptr_n    = ptr + 8'd1;
                            state_n  = RACK;
                        end else begin
                            tx_n     = {tx[6:0], tx[7]};
                            sda_oe_n = ~tx[6];
                            cnt_n    = cnt + 4'd1;
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        nack_n = sda_s;
                    end else if (scl_fall) begin
                        cnt_n = 4'd0;
                        if (nack) begin
                            state_n = IGNORE;
                        end else begin
                            state_n   = RDATA;
                            rd_req_n  = 1'b1;
                            rd_addr_n = ptr;
                        end
                    end
                end
                IDLE, IGNORE: ;
                default: begin
                    state_n  = IDLE;
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            shreg    <= 8'h00;
            tx       <= 8'h00;
            ptr      <= 8'h00;
            rw       <= 1'b0;
            nack     <= 1'b0;
            sda_oe   <= 1'b0;
            rd_req_d <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= 8'h00;
            wr_data  <= 8'h00;
            rd_req   <= 1'b0;
            rd_addr  <= 8'h00;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            shreg    <= shreg_n;
            tx       <= tx_n;
            ptr      <= ptr_n;
            rw       <= rw_n;
            nack     <= nack_n;
            sda_oe   <= sda_oe_n;
            rd_req_d <= rd_req;
            wr_valid <= wr_valid_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
            rd_req   <= rd_req_n;
            rd_addr  <= rd_addr_n;
        end
    end

    assign drive_ok = (state == ADDR_ACK) || (state == REG_ACK) ||
                      (state == WDATA_ACK) || (state == RDATA);
    assign i2c_sda  = (sda_oe && drive_ok) ? 1'b0 : 1'bz;
    assign busy     = (state != IDLE) && (state != IGNORE);

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C controller, scoreboard queues for wr/rd strobes.
module tb_i2c_target;
    logic       clk = 1'b0;
    logic       rst_n, scl, ctl_low;
    wire        sda;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
    logic       wr_valid, rd_req, busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic        watch_drv, watch_busy;
    int          drv_cnt, busy_cnt;
    logic        rd_hit;
    logic [7:0]  rd_val;

    pullup (sda);
    assign sda = ctl_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_target #(.TARGET_ADDR(7'h1A)) dut (
        .clk(clk), .rst_n(rst_n), .i2c_scl(scl), .i2c_sda(sda),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid),
        .rd_addr(rd_addr), .rd_req(rd_req), .rd_data(rd_data), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Register file model: data valid only in the cycle the DUT is meant to sample it.
    always @(negedge clk) begin
        rd_data = 8'h00;
        if (rd_hit) rd_data = rd_val;
        rd_hit = rd_req;
        rd_val = rd_addr + 8'h80;
    end

    // Monitor: pops expected strobes as the DUT presents them.
    always @(negedge clk) begin
        if (wr_valid) begin
            if (exp_wr.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no strobe", wr_addr, wr_data);
            end else begin
                logic [15:0] e;
                e = exp_wr.pop_front();
                check("wr_addr", {24'd0, wr_addr}, {24'd0, e[15:8]});
                check("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
            end
        end
        if (rd_req) begin
            if (exp_rd.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rd_unexpected: got rd_addr 0x%0h, expected no rd_req", rd_addr);
            end else begin
                logic [7:0] r;
                r = exp_rd.pop_front();
                check("rd_addr", {24'd0, rd_addr}, {24'd0, r});
            end
        end
        if (watch_drv && !ctl_low && sda === 1'b0) drv_cnt++;
        if (watch_busy && busy) busy_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_bit(input logic b);
        wait_n(4); ctl_low = ~b;
        wait_n(4); scl = 1'b1;
        wait_n(8); scl = 1'b0;
    endtask

    task automatic get_bit(output logic b);
        wait_n(4); ctl_low = 1'b0;
        wait_n(4); scl = 1'b1;
        wait_n(4); b = sda;
        wait_n(4); scl = 1'b0;
    endtask

    task automatic i2c_start;
        wait_n(4); ctl_low = 1'b0;
        wait_n(4); scl = 1'b1;
        wait_n(4); ctl_low = 1'b1;
        wait_n(4); scl = 1'b0;
    endtask

    task automatic i2c_stop;
        wait_n(4); ctl_low = 1'b1;
        wait_n(4); scl = 1'b1;
        wait_n(4); ctl_low = 1'b0;
        wait_n(4);
    endtask

    task automatic put_byte(input logic [7:0] v, input logic exp_ack, input string name);
        logic a;
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(a);
        check(name, {31'd0, a}, {31'd0, exp_ack});
    endtask

    task automatic get_byte(input logic [7:0] exp, input logic nack, input string name);
        logic [7:0] v;
        logic       b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
        check(name, {24'd0, v}, {24'd0, exp});
        put_bit(nack);
    endtask

    initial begin
        rst_n = 1'b0; scl = 1'b1; ctl_low = 1'b0;
        watch_drv = 1'b0; watch_busy = 1'b0; drv_cnt = 0; busy_cnt = 0;
        rd_hit = 1'b0; rd_val = 8'h00; rd_data = 8'h00;
        wait_n(3);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        check("rst_rd_req",   {31'd0, rd_req},   32'd0);
        check("rst_wr_addr",  {24'd0, wr_addr},  32'd0);
        check("rst_wr_data",  {24'd0, wr_data},  32'd0);
        check("rst_rd_addr",  {24'd0, rd_addr},  32'd0);
        check("rst_sda",      {31'd0, sda},      32'd1);
        rst_n = 1'b1;
        wait_n(8);

        // Single write
        exp_wr.push_back({8'h05, 8'hA5});
        i2c_start;
        put_byte(8'h34, 1'b0, "w_addr_ack");
        check("w_busy_mid", {31'd0, busy}, 32'd1);
        put_byte(8'h05, 1'b0, "w_reg_ack");
        put_byte(8'hA5, 1'b0, "w_data_ack");
        i2c_stop;
        wait_n(4);
        check("w_busy_after_p", {31'd0, busy}, 32'd0);

        // Wrong address: never acked, never busy once the address is rejected
        drv_cnt = 0; busy_cnt = 0; watch_drv = 1'b1;
        i2c_start;
        put_byte(8'h36, 1'b1, "x_addr_nack");
        watch_busy = 1'b1;
        put_byte(8'h05, 1'b1, "x_reg_nack");
        put_byte(8'hA5, 1'b1, "x_data_nack");
        i2c_stop;
        wait_n(8);
        watch_drv = 1'b0; watch_busy = 1'b0;
        check("x_sda_driven_cycles", drv_cnt, 32'd0);
        check("x_busy_cycles", busy_cnt, 32'd0);

        // Burst write across the pointer wrap
        exp_wr.push_back({8'hFF, 8'h11});
        exp_wr.push_back({8'h00, 8'h22});
        i2c_start;
        put_byte(8'h34, 1'b0, "b_addr_ack");
        put_byte(8'hFF, 1'b0, "b_reg_ack");
        put_byte(8'h11, 1'b0, "b_d0_ack");
        put_byte(8'h22, 1'b0, "b_d1_ack");
        i2c_stop;
        wait_n(8);

        // Combined read with repeated START
        exp_rd.push_back(8'h10);
        exp_rd.push_back(8'h11);
        i2c_start;
        put_byte(8'h34, 1'b0, "r_waddr_ack");
        put_byte(8'h10, 1'b0, "r_reg_ack");
        i2c_start;
        put_byte(8'h35, 1'b0, "r_raddr_ack");
        get_byte(8'h90, 1'b0, "r_byte0");
        get_byte(8'h91, 1'b1, "r_byte1");
        wait_n(6);
        check("r_sda_after_nack", {31'd0, sda}, 32'd1);
        i2c_stop;
        wait_n(8);
        check("r_busy_after_p", {31'd0, busy}, 32'd0);

        // Reset during the 4th bit of the data byte (bit value 0, SCL high)
        i2c_start;
        put_byte(8'h34, 1'b0, "z_addr_ack");
        put_byte(8'h07, 1'b0, "z_reg_ack");
        put_bit(1'b1); put_bit(1'b1); put_bit(1'b0);
        wait_n(4); ctl_low = 1'b1;
        wait_n(4); scl = 1'b1;
        wait_n(3); rst_n = 1'b0;
        wait_n(2);
        check("z_busy_in_rst", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        drv_cnt = 0; watch_drv = 1'b1;
        wait_n(3); scl = 1'b0;
        put_byte({4'b0011, 4'h0}, 1'b1, "z_no_ack_after_rst");
        i2c_stop;
        wait_n(8);
        watch_drv = 1'b0;
        check("z_sda_driven_cycles", drv_cnt, 32'd0);

        exp_wr.push_back({8'h02, 8'h3C});
        i2c_start;
        put_byte(8'h34, 1'b0, "z2_addr_ack");
        put_byte(8'h02, 1'b0, "z2_reg_ack");
        put_byte(8'h3C, 1'b0, "z2_data_ack");
        i2c_stop;
        wait_n(8);

        check("wr_pending", exp_wr.size(), 32'd0);
        check("rd_pending", exp_rd.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
